// File: rtl/user_out_arbiter.sv
// Round-robin burst arbiter: N user streams into one registered output slot.
// A grant lasts up to BURST_LEN words; releasing it costs one IDLE cycle.
module user_out_arbiter #(
    parameter int PAYLOAD_BITS = 32,
    parameter int NUM_REQ      = 2,
    parameter int REQ_BITS     = 1,
    parameter int BURST_LEN    = 4
) (
    input  logic                            clk_user,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
    input  logic [NUM_REQ-1:0]              vld_req,
    output logic [NUM_REQ-1:0]              ack_req,
    output logic [PAYLOAD_BITS-1:0]         dout,
    output logic [REQ_BITS-1:0]             dout_src,
    output logic                            vld_out,
    input  logic                            ack_out
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state;
    logic [REQ_BITS-1:0]     grant;
    logic [REQ_BITS-1:0]     rr_ptr;
    logic [REQ_BITS-1:0]     pick;
    logic [REQ_BITS-1:0]     next_ptr;
    logic [CNT_W-1:0]        cnt;
    logic                    found;
    logic                    slot_free;
    logic                    g_vld;
    logic                    accept;
    logic [PAYLOAD_BITS-1:0] g_din;

    assign slot_free = !vld_out || ack_out;
    assign g_vld     = vld_req[grant];
    assign g_din     = din_req[grant*PAYLOAD_BITS +: PAYLOAD_BITS];
    // ack is gated by reset so nothing is taken while reset is low
    assign accept    = reset && (state == GRANT) && g_vld && slot_free;
    assign next_ptr  = REQ_BITS'((int'(grant) + 1) % NUM_REQ);

    // Only the granted requester can see an accept
    always_comb begin
        ack_req = '0;
        if (accept) ack_req[grant] = 1'b1;
    end

    // First valid requester at or after rr_ptr; reverse scan so lowest offset wins
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (vld_req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick  = REQ_BITS'((int'(rr_ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    // Grant FSM plus the registered output slot
    always_ff @(posedge clk_user) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            dout     <= '0;
            dout_src <= '0;
            vld_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!g_vld || (accept && cnt == CNT_LAST)) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else if (accept) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                dout     <= g_din;
                dout_src <= grant;
                vld_out  <= 1'b1;
            end else if (ack_out) begin
                vld_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_user_out_arbiter.sv
// Directed bench for user_out_arbiter (2 requesters, burst of 4).
// Expected values are hand-derived cycle by cycle.
module tb_user_out_arbiter;

    logic        clk_user = 1'b0;
    logic        reset;
    logic [63:0] din_req;
    logic [1:0]  vld_req;
    logic [1:0]  ack_req;
    logic [31:0] dout;
    logic [0:0]  dout_src;
    logic        vld_out;
    logic        ack_out;

    int n_chk  = 0;
    int n_pass = 0;

    int exp_s[12] = '{-1, 0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 0};

    user_out_arbiter #(
        .PAYLOAD_BITS(32),
        .NUM_REQ(2),
        .REQ_BITS(1),
        .BURST_LEN(4)
    ) dut (
        .clk_user(clk_user),
        .reset(reset),
        .din_req(din_req),
        .vld_req(vld_req),
        .ack_req(ack_req),
        .dout(dout),
        .dout_src(dout_src),
        .vld_out(vld_out),
        .ack_out(ack_out)
    );

    always #5 clk_user = ~clk_user;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_user);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        din_req = '0;
        vld_req = 2'b11;
        ack_out = 1'b1;
        step();
        step();
        settle();
        chk("rst_vld", 32'(vld_out), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_src", 32'(dout_src), 32'd0);
        chk("rst_ack", 32'(ack_req), 32'd0);

        // requester 0 streams 0x11,0x22,0x33
        vld_req       = 2'b01;
        din_req[31:0] = 32'h11;
        reset         = 1'b1;
        step();
        chk("t1_arb_vld", 32'(vld_out), 32'd0);
        chk("t1_ack0", 32'(ack_req), 32'd1);
        step();
        chk("t1_w0", dout, 32'h11);
        chk("t1_src0", 32'(dout_src), 32'd0);
        chk("t1_v0", 32'(vld_out), 32'd1);
        din_req[31:0] = 32'h22;
        step();
        chk("t1_w1", dout, 32'h22);
        din_req[31:0] = 32'h33;
        step();
        chk("t1_w2", dout, 32'h33);
        chk("t1_src2", 32'(dout_src), 32'd0);
        vld_req = 2'b00;
        step();
        chk("t1_drain", 32'(vld_out), 32'd0);

        // both requesters always valid: 4 src0, bubble, 4 src1, bubble
        do_reset();
        din_req = {32'h200, 32'h100};
        vld_req = 2'b11;
        for (int k = 0; k < 12; k++) begin
            step();
            if (exp_s[k] < 0) begin
                chk($sformatf("t2_idle%0d", k), 32'(vld_out), 32'd0);
            end else begin
                chk($sformatf("t2_vld%0d", k), 32'(vld_out), 32'd1);
                chk($sformatf("t2_src%0d", k), 32'(dout_src), 32'(exp_s[k]));
                chk($sformatf("t2_dat%0d", k), dout,
                    (exp_s[k] == 1) ? 32'h200 : 32'h100);
            end
        end

        // backpressure holds 0xAA for three cycles
        do_reset();
        vld_req       = 2'b01;
        din_req[31:0] = 32'hAA;
        step();
        step();
        chk("t3_aa", dout, 32'hAA);
        ack_out       = 1'b0;
        din_req[31:0] = 32'hBB;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("t3_ack%0d", k), 32'(ack_req), 32'd0);
            step();
            chk($sformatf("t3_hold%0d", k), dout, 32'hAA);
            chk($sformatf("t3_hv%0d", k), 32'(vld_out), 32'd1);
        end
        ack_out = 1'b1;
        settle();
        chk("t3_ackrise", 32'(ack_req), 32'd1);
        step();
        chk("t3_bb", dout, 32'hBB);
        vld_req = 2'b00;
        step();

        // requester 1 drops after 2 words; rr_ptr returns to 0
        vld_req        = 2'b11;
        din_req[63:32] = 32'h51;
        din_req[31:0]  = 32'h61;
        step();
        chk("t4_ack1", 32'(ack_req), 32'd2);
        step();
        chk("t4_w51", dout, 32'h51);
        din_req[63:32] = 32'h52;
        step();
        chk("t4_w52", dout, 32'h52);
        chk("t4_src", 32'(dout_src), 32'd1);
        vld_req = 2'b01;
        settle();
        chk("t4_drop_ack", 32'(ack_req), 32'd0);
        step();
        chk("t4_rel_vld", 32'(vld_out), 32'd0);
        chk("t4_idle_ack", 32'(ack_req), 32'd0);
        step();
        chk("t4_ack0", 32'(ack_req), 32'd1);
        step();
        chk("t4_w61", dout, 32'h61);
        chk("t4_src0", 32'(dout_src), 32'd0);

        // finish burst of 0, requester 1 granted, then reset mid-burst
        vld_req = 2'b11;
        step();
        step();
        step();
        step();
        step();
        chk("t5_g1_src", 32'(dout_src), 32'd1);
        chk("t5_g1_vld", 32'(vld_out), 32'd1);
        reset = 1'b0;
        settle();
        chk("t5_rst_ack", 32'(ack_req), 32'd0);
        step();
        chk("t5_rst_vld", 32'(vld_out), 32'd0);
        chk("t5_rst_dout", dout, 32'd0);
        reset = 1'b1;
        step();
        chk("t5_first0", 32'(ack_req), 32'd1);
        step();
        chk("t5_src", 32'(dout_src), 32'd0);
        chk("t5_dat", dout, 32'h61);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/user_out_arbiter.md
USER_OUT_ARBITER -- requirements
Module: user_out_arbiter

Interface
REQ-001 The block SHALL expose parameter PAYLOAD_BITS, default 32: width of each data word.
REQ-002 The block SHALL expose parameter NUM_REQ, default 2: number of user requester streams (2..16).
REQ-003 The block SHALL expose parameter REQ_BITS, default 1: width of the source index, equal to ceil(log2(NUM_REQ)).
REQ-004 The block SHALL expose parameter BURST_LEN, default 4: maximum words per grant (1..64).
REQ-005 The block SHALL have port clk_user, input, 1: the only clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 The block SHALL have port din_req, input, NUM_REQ*PAYLOAD_BITS: requester data, requester i in bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-008 The block SHALL have port vld_req, input, NUM_REQ: per-requester valid.
REQ-009 The block SHALL have port ack_req, output, NUM_REQ: per-requester accept.
REQ-010 The block SHALL have port dout, output, PAYLOAD_BITS: registered output word.
REQ-011 The block SHALL have port dout_src, output, REQ_BITS: index of the requester that supplied dout.
REQ-012 The block SHALL have port vld_out, output, 1: dout/dout_src valid.
REQ-013 The block SHALL have port ack_out, input, 1: downstream accept.

Function
REQ-014 A transfer SHALL occur on a rising edge where the valid and the matching ack are both high; ack may depend combinationally on the valid.
REQ-015 The block SHALL hold one registered output slot; the slot is "free" when vld_out=0 or ack_out=1.
REQ-016 The FSM SHALL have two states, IDLE and GRANT, plus registers grant (REQ_BITS), rr_ptr (REQ_BITS) and cnt (0..BURST_LEN-1).
REQ-017 In IDLE, all ack_req bits SHALL be 0.
REQ-018 In IDLE with any vld_req bit high, the FSM SHALL select the first asserted requester scanning from rr_ptr upward modulo NUM_REQ, load grant, clear cnt and enter GRANT on the next edge; this is a one-cycle arbitration bubble.
REQ-019 In GRANT, ack_req[grant] SHALL equal vld_req[grant] AND slot free; all other ack_req bits SHALL be 0.
REQ-020 On each accepted word, dout SHALL load din_req[grant], dout_src SHALL load grant, and vld_out SHALL be set, so that latency is exactly 1 cycle from accept to vld_out.
REQ-021 When vld_out=1, ack_out=1 and no new word is accepted on the same edge, vld_out SHALL clear.
REQ-022 While vld_out=1 and ack_out=0, dout, dout_src and vld_out SHALL hold stable.
REQ-023 In GRANT, an accepted word with cnt<BURST_LEN-1 SHALL increment cnt.
REQ-024 In GRANT, an accepted word with cnt=BURST_LEN-1 SHALL release the grant.
REQ-025 In GRANT, vld_req[grant]=0 SHALL release the grant on that edge, regardless of slot state.
REQ-026 On release, rr_ptr SHALL load (grant+1) modulo NUM_REQ (wrapping NUM_REQ-1 to 0) and the FSM SHALL enter IDLE.
REQ-027 While the slot is busy in GRANT with vld_req[grant]=1, the state, cnt and grant SHALL hold.
REQ-028 Changes of vld_req on non-granted requesters SHALL have no effect until the next IDLE cycle.
REQ-029 With sustained valid and ack_out=1, throughput SHALL be BURST_LEN words per BURST_LEN+1 cycles.
REQ-030 Words SHALL never be dropped, duplicated or reordered within a requester.

Reset
REQ-031 With reset=0 at an edge, the block SHALL set state=IDLE, rr_ptr=0, grant=0, cnt=0, vld_out=0, dout=0 and dout_src=0.
REQ-032 During reset, ack_req SHALL be 0.
REQ-033 Reset in mid-burst SHALL discard any word held in the output slot, and the first grant after reset SHALL scan from requester 0.

Verification
REQ-034 Requester 0 offers 0x11,0x22,0x33 back-to-back, ack_out=1 -> first ack_req[0] at cycle 2 after reset release; dout=0x11,0x22,0x33 on consecutive cycles with dout_src=0.
REQ-035 Both requesters continuously valid, BURST_LEN=4 -> output pattern 4 words src0, 1 idle cycle, 4 words src1, 1 idle cycle, repeating.
REQ-036 vld_out=1 with dout=0xAA, then ack_out=0 for 3 cycles -> dout=0xAA stable, ack_req=0; the next word follows the ack_out rise.
REQ-037 Requester 1 granted, drops vld_req[1] after 2 words while requester 0 is valid -> release; rr_ptr=0; requester 0 granted after one IDLE cycle.
REQ-038 reset=0 asserted mid-burst with vld_out=1 -> next cycle vld_out=0 and ack_req=0; after release, the first grant goes to requester 0 when both requesters are valid.
